// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first.
//
// An internal fractional phase accumulator generates an oversampling tick
// (oversampling ticks per bit) directly from the system clock. The rx line is
// passed through a two-flop synchroniser, the start bit is validated at
// mid-bit and every data bit is then sampled one full bit period later.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   reset        asynchronous, active-high reset
//   rx           serial line, idle high, asynchronous to clk
//   rx_data      last correctly framed byte, held until the next good frame
//   rx_valid     one-clk pulse when rx_data is updated
//   frame_error  one-clk pulse when the stop bit samples low
//   busy         high from start-bit detection until return to idle
`timescale 1ns / 1ps

module uart_rx #(
    parameter int unsigned clk_frequency = 25000000,
    parameter int unsigned baud          = 115200,
    // Ticks per bit; must be a power of two between 4 and 16.
    parameter int unsigned oversampling  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_error,
    output logic       busy
);

    // ------------------------------------------------------------------
    // Tick generator
    // ------------------------------------------------------------------
    // Fractional width: ceil(log2(clk_frequency / baud)) + 8. The ceiling
    // division keeps the log ceiling correct for non-integer ratios.
    localparam int unsigned AccW = $clog2((clk_frequency + baud - 1) / baud) + 8;

    localparam longint unsigned Scale   = 64'd1 << AccW;
    localparam longint unsigned IncNum  = longint'(baud) * longint'(oversampling) * Scale;
    // Rounded to nearest: (num + den/2) / den.
    localparam longint unsigned IncWide = (IncNum + longint'(clk_frequency) / 2)
                                          / longint'(clk_frequency);
    localparam logic [AccW-1:0] Inc     = AccW'(IncWide);

    // Bit AccW is the carry; it is dropped before each add so the tick is
    // exactly one clock wide.
    logic [AccW:0] acc_q;
    logic [AccW:0] acc_d;
    logic          tick;

    assign acc_d = {1'b0, acc_q[AccW-1:0]} + {1'b0, Inc};
    assign tick  = acc_q[AccW];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    logic rx_meta_q;
    logic rxs_q;

    // Reset to the idle line level so a reset does not look like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    localparam int unsigned OsW = $clog2(oversampling);

    // Start bit is checked half a bit after detection, data and stop bits
    // a full bit after the previous sample.
    localparam logic [OsW-1:0] OsHalf = OsW'(oversampling / 2 - 1);
    localparam logic [OsW-1:0] OsLast = OsW'(oversampling - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_e;

    state_e         state_q, state_d;
    logic [OsW-1:0] os_cnt_q, os_cnt_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic [7:0]     data_q, data_d;
    logic           valid_q, valid_d;
    logic           ferr_q, ferr_d;
    logic           busy_q, busy_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            os_cnt_q  <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            os_cnt_q  <= os_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        os_cnt_d  = os_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        busy_d    = busy_q;

        unique case (state_q)
            StIdle: begin
                if (tick && !rxs_q) begin
                    state_d  = StStart;
                    os_cnt_d = '0;
                    busy_d   = 1'b1;
                end
            end

            StStart: begin
                if (tick) begin
                    if (os_cnt_q == OsHalf) begin
                        if (rxs_q) begin
                            // Line went high again before mid-bit: glitch.
                            state_d = StIdle;
                            busy_d  = 1'b0;
                        end else begin
                            os_cnt_d  = '0;
                            bit_cnt_d = '0;
                            state_d   = StData;
                        end
                    end else begin
                        os_cnt_d = os_cnt_q + 1'b1;
                    end
                end
            end

            StData: begin
                if (tick) begin
                    if (os_cnt_q == OsLast) begin
                        os_cnt_d = '0;
                        // Right shift: first bit received ends up in bit 0.
                        shift_d  = {rxs_q, shift_q[7:1]};
                        if (bit_cnt_q == 3'd7) begin
                            state_d = StStop;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end else begin
                        os_cnt_d = os_cnt_q + 1'b1;
                    end
                end
            end

            StStop: begin
                if (tick) begin
                    if (os_cnt_q == OsLast) begin
                        os_cnt_d = '0;
                        if (rxs_q) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                            state_d = StIdle;
                            busy_d  = 1'b0;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = StBreak;
                        end
                    end else begin
                        os_cnt_d = os_cnt_q + 1'b1;
                    end
                end
            end

            StBreak: begin
                // Wait out a held-low line so it reports only one error.
                if (tick && rxs_q) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end
            end

            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign rx_data     = data_q;
    assign rx_valid    = valid_q;
    assign frame_error = ferr_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at the default parameters
// (25 MHz clock, 115200 bps, 8x oversampling). Frames are driven on rx with
// real-valued bit times; a negedge monitor records every rx_valid byte and
// frame_error pulse, and the main sequence checks those records.
`timescale 1ns / 1ps

module tb_uart_rx;

    localparam real Bit115 = 1.0e9 / 115200.0;
    localparam real Bit129 = 1.0e9 / 112900.0;
    localparam real Bit175 = 1.0e9 / 117500.0;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       rx    = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_error;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] got[$];
    int         ferr_cnt     = 0;
    int         both_cnt     = 0;
    int         busy_fall_ok = 0;
    logic       busy_prev    = 1'b0;

    uart_rx dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_error (frame_error),
        .busy        (busy)
    );

    always #20 clk = ~clk;

    // Monitor sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rx_valid) begin
            got.push_back(rx_data);
            if (busy_prev && !busy) busy_fall_ok++;
        end
        if (frame_error) ferr_cnt++;
        if (rx_valid && frame_error) both_cnt++;
        busy_prev = busy;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input real bit_ns);
        rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(bit_ns);
        end
        rx = stop_bit;
        #(bit_ns);
    endtask

    task automatic idle_bits(input int n, input real bit_ns);
        rx = 1'b1;
        for (int i = 0; i < n; i++) #(bit_ns);
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (4) @(negedge clk);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_valid", rx_valid, 1'b0);
        check("reset_frame_error", frame_error, 1'b0);
        check("reset_busy", busy, 1'b0);
        reset = 1'b0;
        idle_bits(2, Bit115);

        // Single byte
        send_frame(8'h55, 1'b1, Bit115);
        idle_bits(1, Bit115);
        check("single_count", got.size(), 1);
        check("single_data", got[0], 8'h55);
        check("single_rx_data", rx_data, 8'h55);
        check("single_ferr", ferr_cnt, 0);
        check("single_busy_fall", busy_fall_ok, 1);
        check("single_busy_idle", busy, 1'b0);

        // Back-to-back frames, no idle gap
        send_frame(8'hA3, 1'b1, Bit115);
        send_frame(8'h0F, 1'b1, Bit115);
        send_frame(8'hFF, 1'b1, Bit115);
        send_frame(8'h00, 1'b1, Bit115);
        idle_bits(2, Bit115);
        check("b2b_count", got.size(), 5);
        check("b2b_data0", got[1], 8'hA3);
        check("b2b_data1", got[2], 8'h0F);
        check("b2b_data2", got[3], 8'hFF);
        check("b2b_data3", got[4], 8'h00);
        check("b2b_ferr", ferr_cnt, 0);

        // Glitch shorter than half a bit
        @(negedge clk);
        rx = 1'b0;
        repeat (60) @(negedge clk);
        check("glitch_busy_high", busy, 1'b1);
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        check("glitch_busy_low", busy, 1'b0);
        check("glitch_count", got.size(), 5);
        check("glitch_ferr", ferr_cnt, 0);
        idle_bits(1, Bit115);

        // Framing error, held break, then recovery
        send_frame(8'h3C, 1'b0, Bit115);
        rx = 1'b0;
        #(3.0 * Bit115);
        idle_bits(2, Bit115);
        check("ferr_count", ferr_cnt, 1);
        check("ferr_no_valid", got.size(), 5);
        check("ferr_rx_data_held", rx_data, 8'h00);
        check("ferr_busy_idle", busy, 1'b0);
        send_frame(8'h81, 1'b1, Bit115);
        idle_bits(1, Bit115);
        check("after_ferr_count", got.size(), 6);
        check("after_ferr_data", rx_data, 8'h81);
        check("after_ferr_ferr", ferr_cnt, 1);

        // Reset during bit 4 of 0xC6
        rx = 1'b0;
        #(Bit115);
        for (int i = 0; i < 4; i++) begin
            rx = (8'hC6 >> i) & 8'h01;
            #(Bit115);
        end
        rx = 1'b0;                                  // bit 4 of 0xC6
        #(0.5 * Bit115);
        check("midframe_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        check("rst_async_busy", busy, 1'b0);
        check("rst_async_rx_data", rx_data, 8'h00);
        check("rst_async_rx_valid", rx_valid, 1'b0);
        check("rst_async_ferr", frame_error, 1'b0);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        idle_bits(2, Bit115);
        check("rst_no_pulse_count", got.size(), 6);
        send_frame(8'h5A, 1'b1, Bit115);
        idle_bits(1, Bit115);
        check("rst_recover_count", got.size(), 7);
        check("rst_recover_data", rx_data, 8'h5A);

        // Baud tolerance, about -2% and +2%
        send_frame(8'h96, 1'b1, Bit129);
        idle_bits(1, Bit129);
        check("slow_count", got.size(), 8);
        check("slow_data", rx_data, 8'h96);
        send_frame(8'h96, 1'b1, Bit175);
        idle_bits(1, Bit175);
        check("fast_count", got.size(), 9);
        check("fast_data", got[8], 8'h96);

        // Whole-run properties
        check("total_ferr", ferr_cnt, 1);
        check("valid_ferr_exclusive", both_cnt, 0);
        check("busy_fall_every_valid", busy_fall_ok, got.size());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
